// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, controller states, datapath select encodings.
package riscv_pkg;

    // Opcodes of the supported instruction subset
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    // Multicycle controller states (State debug port shows these codes)
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StHalt     = 4'd12
    } state_t;

    // ALUControl codes; ALUAlt selects sub (with add) or sra (with srl)
    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSll  = 3'b001,
        AluSlt  = 3'b010,
        AluSltu = 3'b011,
        AluXor  = 3'b100,
        AluSrl  = 3'b101,
        AluOr   = 3'b110,
        AluAnd  = 3'b111
    } alu_ctrl_t;

    // Operation class handed from the sequencer to the ALU decoder
    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResReadData  = 2'b01,
        ResAluResult = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcAOldPc = 2'b01,
        SrcARs1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SrcBRs2  = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        ImmI = 2'b00,
        ImmS = 2'b01,
        ImmB = 2'b10,
        ImmJ = 2'b11
    } imm_src_t;

    // Immediate format implied by the opcode; unknown opcodes fall back to I-type
    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        imm_src_t imm;
        imm = ImmI;
        case (op)
            OpStore:  imm = ImmS;
            OpBranch: imm = ImmB;
            OpJal:    imm = ImmJ;
            default:  imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the operation class and funct fields onto ALUControl/ALUAlt.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  alu_op_t    alu_op,
    output logic [2:0] alu_control,
    output logic       alu_alt
);

    logic r_type;

    // funct7b5 is an operand modifier for R-type; for OP-IMM it only means srai
    assign r_type = (op == OpOp);

    // Select the ALU operation for the current class
    always_comb begin
        alu_control = AluAdd;
        alu_alt     = 1'b0;
        unique case (alu_op)
            AluOpAdd: begin
                alu_control = AluAdd;
            end
            AluOpSub: begin
                alu_control = AluAdd;
                alu_alt     = 1'b1;
            end
            AluOpFunct: begin
                alu_control = funct3;
                alu_alt     = funct7b5 & (r_type | (funct3 == AluSrl));
            end
            default: begin
                alu_control = AluAdd;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: steps one instruction through a shared ALU and memory port.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ILLEGAL_HALT  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       Lt,
    input  logic       Ltu,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       ALUAlt,
    output logic [1:0] ImmSrc,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic        mem_ready;
    logic        taken;
    logic        pc_write, adr_src, ir_write, mem_write, reg_write;
    logic        illegal_pulse;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    alu_op_t     alu_op;

    assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

    // Branch condition from the comparator flags; funct3 010/011 never branch
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = ~Lt;
            3'b110:  taken = Ltu;
            3'b111:  taken = ~Ltu;
            default: taken = 1'b0;
        endcase
    end

    // State register and sticky illegal flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        result_src    = ResAluOut;
        alu_src_a     = SrcAPc;
        alu_src_b     = SrcBRs2;
        alu_op        = AluOpAdd;
        illegal_pulse = 1'b0;

        unique case (state_q)
            StFetch: begin
                // PC + 4 goes straight from ALUResult into PC as the fetch completes
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                pc_write   = mem_ready;
                ir_write   = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // OldPC + imm is latched into ALUOut as the branch/jal target
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                unique case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpOp:            state_d = StExecR;
                    OpImm:           state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    default: begin
                        illegal_pulse = 1'b1;
                        if (ILLEGAL_HALT) begin
                            state_d   = StHalt;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src    = 1'b1;
                result_src = ResAluOut;
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src = ResReadData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                // Strobe held for the whole wait so the memory sees a stable request
                adr_src    = 1'b1;
                result_src = ResAluOut;
                mem_write  = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StJalr: begin
                // rs1 + imm replaces the DECODE target in ALUOut, then shares the JAL path
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = StJal;
            end
            StJal: begin
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluOut;
                pc_write   = 1'b1;
                state_d    = StAluWb;
            end
            StBranch: begin
                alu_src_a     = SrcARs1;
                alu_src_b     = SrcBRs2;
                alu_op        = AluOpSub;
                result_src    = ResAluOut;
                pc_write      = taken;
                illegal_pulse = (funct3 == 3'b010) | (funct3 == 3'b011);
                state_d       = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_op      (alu_op),
        .alu_control (ALUControl),
        .alu_alt     (ALUAlt)
    );

    // Write strobes are held off combinationally while reset is asserted
    assign PCWrite   = pc_write & ~reset;
    assign IRWrite   = ir_write & ~reset;
    assign MemWrite  = mem_write & ~reset;
    assign RegWrite  = reg_write & ~reset;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign ImmSrc    = imm_src_of(op);
    assign Illegal   = illegal_q | illegal_pulse;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: instruction-level model predicts every cycle.
module tb_multicycle_controller;
    import riscv_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       irw;
        logic       memw;
        logic       regw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] ac;
        logic       alt;
        logic [1:0] imm;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, MemReady = 1'b0;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUAlt, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int total = 0;
    int bad = 0;
    ctl_t  exp_q[$];
    string name_q[$];

    // Current instruction fields, applied to the DUT inputs on each driven cycle
    logic [6:0] cur_op = 7'b0110011;
    logic [2:0] cur_f3 = 3'b000;
    logic       cur_f7 = 1'b0, cur_z = 1'b0, cur_lt = 1'b0, cur_ltu = 1'b0;
    string      cur_name = "reset";

    multicycle_controller #(
        .MEM_HANDSHAKE (1'b1),
        .ILLEGAL_HALT  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .Lt         (Lt),
        .Ltu        (Ltu),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ALUAlt     (ALUAlt),
        .ImmSrc     (ImmSrc),
        .Illegal    (Illegal),
        .State      (State)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic known_op(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
               (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111) ||
               (o == 7'b1100111);
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic br_taken();
        case (cur_f3)
            3'd0: return cur_z;
            3'd1: return !cur_z;
            3'd4: return cur_lt;
            3'd5: return !cur_lt;
            3'd6: return cur_ltu;
            3'd7: return !cur_ltu;
            default: return 1'b0;
        endcase
    endfunction

    // Expected controls for one cycle spent in state s
    function automatic ctl_t mk(input state_t s, input logic mr);
        ctl_t e;
        e = '0;
        e.st  = s;
        e.imm = imm_of(cur_op);
        case (s)
            StFetch:    begin e.sb = 2'b10; e.rs = 2'b10; e.pcw = mr; e.irw = mr; end
            StDecode:   begin e.sa = 2'b01; e.sb = 2'b01; e.ill = !known_op(cur_op); end
            StMemAdr:   begin e.sa = 2'b10; e.sb = 2'b01; end
            StMemRead:  begin e.adr = 1'b1; end
            StMemWb:    begin e.rs = 2'b01; e.regw = 1'b1; end
            StMemWrite: begin e.adr = 1'b1; e.memw = 1'b1; end
            StExecR:    begin e.sa = 2'b10; e.ac = cur_f3; e.alt = cur_f7; end
            StExecI:    begin
                e.sa = 2'b10; e.sb = 2'b01; e.ac = cur_f3;
                e.alt = cur_f7 && (cur_f3 == 3'd5);
            end
            StAluWb:    begin e.regw = 1'b1; end
            StJalr:     begin e.sa = 2'b10; e.sb = 2'b01; end
            StJal:      begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            StBranch:   begin
                e.sa = 2'b10; e.alt = 1'b1; e.pcw = br_taken();
                e.ill = (cur_f3 == 3'd2) || (cur_f3 == 3'd3);
            end
            StHalt:     begin e.ill = 1'b1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    // Apply inputs just after the active edge and queue what the DUT must show this cycle
    task automatic drive(input logic rst, input logic mr, input ctl_t e);
        @(posedge clk);
        #1;
        reset = rst; op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7;
        Zero = cur_z; Lt = cur_lt; Ltu = cur_ltu; MemReady = mr;
        exp_q.push_back(e);
        name_q.push_back(cur_name);
    endtask

    task automatic step(input state_t s, input logic mr);
        drive(1'b0, mr, mk(s, mr));
    endtask

    // Idle-irrelevant MemReady is randomised so it must not leak into other states
    task automatic step_any(input state_t s);
        logic mr;
        mr = 1'($urandom_range(0, 1));
        step(s, mr);
    endtask

    task automatic hold_reset(input int n);
        ctl_t e;
        logic mr;
        cur_name = "reset";
        for (int i = 0; i < n; i++) begin
            mr = 1'($urandom_range(0, 1));
            e = mk(StFetch, mr);
            e.pcw = 1'b0;
            e.irw = 1'b0;
            drive(1'b1, mr, e);
        end
    endtask

    // Whole-instruction sequence from the opcode class and memory wait counts
    task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic lt, input logic ltu,
                             input int fw, input int mw);
        cur_name = nm; cur_op = o; cur_f3 = f3; cur_f7 = f7;
        cur_z = z; cur_lt = lt; cur_ltu = ltu;
        repeat (fw) step(StFetch, 1'b0);
        step(StFetch, 1'b1);
        step_any(StDecode);
        case (o)
            7'b0000011: begin
                step_any(StMemAdr);
                repeat (mw) step(StMemRead, 1'b0);
                step(StMemRead, 1'b1);
                step_any(StMemWb);
            end
            7'b0100011: begin
                step_any(StMemAdr);
                repeat (mw) step(StMemWrite, 1'b0);
                step(StMemWrite, 1'b1);
            end
            7'b0110011: begin step_any(StExecR); step_any(StAluWb); end
            7'b0010011: begin step_any(StExecI); step_any(StAluWb); end
            7'b1100011: step_any(StBranch);
            7'b1101111: begin step_any(StJal); step_any(StAluWb); end
            7'b1100111: begin step_any(StJalr); step_any(StJal); step_any(StAluWb); end
            default:    repeat (20) step_any(StHalt);
        endcase
    endtask

    // ---------------- monitor ----------------
    ctl_t  mon_e, mon_a;
    string mon_n;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                mon_a = {State, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                         ALUSrcA, ALUSrcB, ALUControl, ALUAlt, ImmSrc, Illegal};
                total++;
                if (mon_a !== mon_e) begin
                    bad++;
                    $display("FAIL %s @%0t: got st=%0d pcw=%b adr=%b irw=%b mw=%b rw=%b rs=%b sa=%b sb=%b ac=%b alt=%b imm=%b ill=%b | want st=%0d pcw=%b adr=%b irw=%b mw=%b rw=%b rs=%b sa=%b sb=%b ac=%b alt=%b imm=%b ill=%b",
                        mon_n, $time,
                        mon_a.st, mon_a.pcw, mon_a.adr, mon_a.irw, mon_a.memw, mon_a.regw,
                        mon_a.rs, mon_a.sa, mon_a.sb, mon_a.ac, mon_a.alt, mon_a.imm, mon_a.ill,
                        mon_e.st, mon_e.pcw, mon_e.adr, mon_e.irw, mon_e.memw, mon_e.regw,
                        mon_e.rs, mon_e.sa, mon_e.sb, mon_e.ac, mon_e.alt, mon_e.imm, mon_e.ill);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] o;
        hold_reset(2);
        run_instr("add",       7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("lw_wait",   7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3);
        run_instr("sw_wait",   7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        run_instr("bne_z1",    7'b1100011, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr("bne_z0",    7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("bgeu",      7'b1100011, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr("br_f3_010", 7'b1100011, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
        run_instr("jalr",      7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("jal",       7'b1101111, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0);
        run_instr("sub",       7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("srai",      7'b0010011, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("addi_f7",   7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Reset landing in the middle of a store wait
        cur_name = "sw_reset"; cur_op = 7'b0100011; cur_f3 = 3'd2; cur_f7 = 1'b0;
        step(StFetch, 1'b1);
        step_any(StDecode);
        step_any(StMemAdr);
        step(StMemWrite, 1'b0);
        step(StMemWrite, 1'b0);
        hold_reset(1);
        run_instr("after_rst", 7'b0110011, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 6))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                default: o = 7'b1100111;
            endcase
            run_instr("rand", o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)));
        end

        run_instr("illegal", 7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        hold_reset(2);
        run_instr("post_halt", 7'b0110011, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle variant of the RV32I core. One shared ALU and one shared instruction/data memory port per instruction, reused across several cycles.
- Decodes the same instruction subset and ALUControl encoding as the pipelined decode stage: lw, sw, OP-IMM, OP, B-type, jal, jalr.
- Drives datapath mux selects and write strobes state by state, and stalls on a memory-ready handshake.

Parameters:
- MEM_HANDSHAKE, 1: 1 = wait states honour MemReady; 0 = MemReady treated as constant 1.
- ILLEGAL_HALT, 1: 1 = unknown opcode enters HALT until reset; 0 = Illegal pulses for one cycle and the instruction is retired as a NOP (DECODE→FETCH).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; state → FETCH
- op  in  7  opcode from instruction register (IR)
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  comparator: rs1 == rs2
- Lt  in  1  comparator: signed rs1 < rs2
- Ltu  in  1  comparator: unsigned rs1 < rs2
- MemReady  in  1  memory completes the access this cycle
- PCWrite  out  1  load PC from Result
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- IRWrite  out  1  load IR and OldPC
- MemWrite  out  1  store strobe
- RegWrite  out  1  register file write
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUControl  out  3  000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and
- ALUAlt  out  1  1 = sub (with 000) or sra (with 101)
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded from op in every state
- Illegal  out  1  unknown opcode detected
- State  out  4  current state encoding, for debug

Behaviour:
- State register is the only sequential element besides the Illegal flag. All outputs are combinational from state, op, funct3, funct7b5, flags and MemReady.
- Defaults, unless a state says otherwise: all strobes 0, selects 00, ALUControl 000, ALUAlt 0.
- While reset is high:
  - state = FETCH, Illegal = 0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - Selects take FETCH values.
- FETCH:
  - AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10.
  - PCWrite = IRWrite = MemReady.
  - Stay in FETCH until MemReady, then go to DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 01, add (precomputes the branch/jal target into ALUOut). Next state by op:
  - 0000011, 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - other → HALT (ILLEGAL_HALT = 1) or FETCH (ILLEGAL_HALT = 0)
- MEMADR: ALUSrcA 10, ALUSrcB 01, add. Next: MEMREAD if op = lw, else MEMWRITE.
- MEMREAD: AdrSrc 1, ResultSrc 00. Stay until MemReady, then MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1. Next: FETCH.
- MEMWRITE:
  - AdrSrc 1, ResultSrc 00, MemWrite 1, held through the wait.
  - Stay until MemReady, then FETCH.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUControl = funct3, ALUAlt = funct7b5. Next: ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01, ALUControl = funct3, ALUAlt = funct7b5 only when funct3 = 101. Next: ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1. Next: FETCH.
- JALR: ALUSrcA 10, ALUSrcB 01, add (target into ALUOut). Next: JAL. The datapath clears bit 0 of the target.
- JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1 (PC ← target, ALU computes OldPC + 4). Next: ALUWB.
- BRANCH: ALUSrcA 10, ALUSrcB 00, ALUControl 000, ALUAlt 1, ResultSrc 00. PCWrite = taken, where taken is:
  - beq Zero; bne !Zero
  - blt Lt; bge !Lt
  - bltu Ltu; bgeu !Ltu
  - funct3 010/011 → not taken, Illegal pulses for one cycle
  - Next: FETCH.
- HALT: all strobes 0, Illegal = 1, no exit until reset.
- Illegal, ILLEGAL_HALT = 0: high for exactly the DECODE cycle.
- Reset asserted mid-wait (MEMWRITE): MemWrite drops asynchronously; FETCH resumes on the first clk edge after reset deasserts.
- Cycle counts with MemReady = 1: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5. Each MemReady-low cycle adds one cycle in FETCH/MEMREAD/MEMWRITE.

Decomposition:
- riscv_pkg holds:
  - opcode constants
  - state_t enum (4-bit)
  - ALUControl codes
  - ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings
- Sub-module alu_decoder (op, funct3, funct7b5, ALUOp class → ALUControl, ALUAlt), shared with the pipelined decode stage.
- Branch condition stays inline.

Test Plan:
- add x3,x1,x2, MemReady = 1 → States FETCH, DECODE, EXECR, ALUWB; EXECR shows ALUControl 000, ALUAlt 0; RegWrite high only in ALUWB.
- lw, MemReady low 2 cycles in FETCH and 3 cycles in MEMREAD → IRWrite/PCWrite pulse once; RegWrite in the 10th cycle; ResultSrc 01.
- sw with MemReady low 1 cycle → MemWrite high 2 consecutive cycles in MEMWRITE, AdrSrc 1, then FETCH.
- bne with Zero = 1, then with Zero = 0; bgeu with Ltu = 0 → PCWrite 0, 1, 1 respectively in BRANCH; ALUAlt 1.
- jalr → States FETCH, DECODE, JALR, JAL, ALUWB; PCWrite in JAL; RegWrite in ALUWB.
- op = 0000000 with ILLEGAL_HALT = 1 → HALT, Illegal stuck at 1, no strobes for 20 cycles; reset pulse → FETCH, Illegal 0.
